// File: rtl/hazard_controller.sv
// RAW hazard detector and branch flush sequencer for a 5-stage MIPS pipeline.
// Tracks in-flight destinations beside ID and drives stall/bubble/flush plus a stall-cycle counter.
//
// state | meaning
// RUN   | normal operation, hazards evaluated, branch may start a flush
// FLUSH | extra IF/ID flush cycles after a taken branch, ID ignored
module hazard_controller #(
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ID_Valid,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic [4:0]  ID_rDest,
  input  logic        BranchTaken,
  output logic        Stall_PC,
  output logic        Stall_IFID,
  output logic        Bubble_IDEX,
  output logic        Flush_IFID,
  output logic [15:0] StallCycles
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_n;
  logic [2:0]       cnt_q, cnt_n;
  logic [DEPTH-1:0] valid_q;
  logic [4:0]       dest_q [DEPTH];
  logic             load_ex_q;   // only the EX entry's load flag is ever consulted
  logic [DEPTH-1:0] qual;
  logic             match_rs, match_rt;
  logic             run, hazard, issue, br_go;

  always_comb begin
    qual     = '0;
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (FWD_EN != 0) qual[k] = (k == 0) && load_ex_q;
      else             qual[k] = (k < DEPTH - 1);
      if (qual[k] && valid_q[k] && (dest_q[k] == ID_rs)) match_rs = 1'b1;
      if (qual[k] && valid_q[k] && (dest_q[k] == ID_rt)) match_rt = 1'b1;
    end
    match_rs = match_rs && (ID_rs != 5'd0);
    match_rt = match_rt && (ID_rt != 5'd0);
  end

  assign run    = (state_q == RUN);
  assign hazard = ID_Valid && run &&
                  ((ID_UsesRs && match_rs) || (ID_UsesRt && match_rt));
  assign issue  = ID_Valid && ID_RegWrite && (ID_rDest != 5'd0) && !hazard && run;
  assign br_go  = run && BranchTaken && ID_Valid && !hazard;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      RUN: begin
        if (br_go && (BR_PENALTY > 1)) begin
          state_n = FLUSH;
          cnt_n   = 3'(BR_PENALTY - 1);
        end
      end
      FLUSH: begin
        cnt_n = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    Stall_PC    = hazard && !Reset;
    Stall_IFID  = hazard && !Reset;
    Bubble_IDEX = hazard && !Reset;
    Flush_IFID  = !Reset && (run ? br_go : 1'b1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q   <= '0;
      load_ex_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) dest_q[k] <= 5'd0;
    end else begin
      valid_q   <= {valid_q[DEPTH-2:0], issue};
      load_ex_q <= ID_MemRead;
      dest_q[0] <= ID_rDest;
      for (int k = 1; k < DEPTH; k++) dest_q[k] <= dest_q[k-1];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) StallCycles <= 16'd0;
    else if (Stall_PC && (StallCycles != 16'hFFFF)) StallCycles <= StallCycles + 16'd1;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: three instances (load-use with 2-cycle branch
// penalty, no-forwarding, and a deep no-forwarding copy for counter saturation).
module tb_hazard_controller;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset, ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, BranchTaken;
  logic [4:0] ID_rs, ID_rt, ID_rDest;

  logic a_stall_pc, a_stall_ifid, a_bubble, a_flush;
  logic b_stall_pc, b_stall_ifid, b_bubble, b_flush;
  logic c_stall_pc, c_stall_ifid, c_bubble, c_flush;
  logic [15:0] a_cycles, b_cycles, c_cycles;
  logic [3:0] a_out, b_out, c_out;

  assign a_out = {a_stall_pc, a_stall_ifid, a_bubble, a_flush};
  assign b_out = {b_stall_pc, b_stall_ifid, b_bubble, b_flush};
  assign c_out = {c_stall_pc, c_stall_ifid, c_bubble, c_flush};

  int n_cmp = 0;
  int n_bad = 0;

  hazard_controller #(.DEPTH(3), .FWD_EN(1), .BR_PENALTY(2)) dut_a (
    .Clock(Clock), .Reset(Reset), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_rDest(ID_rDest), .BranchTaken(BranchTaken),
    .Stall_PC(a_stall_pc), .Stall_IFID(a_stall_ifid), .Bubble_IDEX(a_bubble),
    .Flush_IFID(a_flush), .StallCycles(a_cycles));

  hazard_controller #(.DEPTH(3), .FWD_EN(0), .BR_PENALTY(1)) dut_b (
    .Clock(Clock), .Reset(Reset), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_rDest(ID_rDest), .BranchTaken(BranchTaken),
    .Stall_PC(b_stall_pc), .Stall_IFID(b_stall_ifid), .Bubble_IDEX(b_bubble),
    .Flush_IFID(b_flush), .StallCycles(b_cycles));

  hazard_controller #(.DEPTH(32), .FWD_EN(0), .BR_PENALTY(1)) dut_c (
    .Clock(Clock), .Reset(Reset), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_rDest(ID_rDest), .BranchTaken(BranchTaken),
    .Stall_PC(c_stall_pc), .Stall_IFID(c_stall_ifid), .Bubble_IDEX(c_bubble),
    .Flush_IFID(c_flush), .StallCycles(c_cycles));

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Outputs are {Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID}; inputs settle before checks.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic mr,
                       input logic [4:0] rd, input logic br);
    ID_Valid = v; ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_RegWrite = rw; ID_MemRead = mr; ID_rDest = rd; BranchTaken = br;
    #2;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    idle();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    drive(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1);
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL reset_forced_a: got %b want %b", a_out, 4'b0000); end
    n_cmp++; if (b_out !== 4'b0000) begin n_bad++; $display("FAIL reset_forced_b: got %b want %b", b_out, 4'b0000); end
    tick();
    tick();
    Reset = 1'b0;
    idle();
    n_cmp++; if (a_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_count_a: got %0d want 0", a_cycles); end
    n_cmp++; if (c_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_count_c: got %0d want 0", c_cycles); end
    n_cmp++; if (c_out !== 4'b0000) begin n_bad++; $display("FAIL reset_idle_c: got %b want %b", c_out, 4'b0000); end
  endtask

  task automatic test_load_use;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);   // lw $8
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL lu_issue: got %b want %b", a_out, 4'b0000); end
    tick();
    drive(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);  // add $9,$8,$10
    n_cmp++; if (a_out !== 4'b1110) begin n_bad++; $display("FAIL lu_stall: got %b want %b", a_out, 4'b1110); end
    tick();
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL lu_release: got %b want %b", a_out, 4'b0000); end
    n_cmp++; if (a_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_count: got %0d want 1", a_cycles); end
    tick();
    idle();
    n_cmp++; if (a_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_count_hold: got %0d want 1", a_cycles); end
  endtask

  task automatic test_uses_flags;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);   // lw $8
    tick();
    drive(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0);
    n_cmp++; if (a_stall_pc !== 1'b0) begin n_bad++; $display("FAIL uses_off: got %b want 0", a_stall_pc); end
    drive(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
    n_cmp++; if (a_stall_pc !== 1'b0) begin n_bad++; $display("FAIL invalid_id: got %b want 0", a_stall_pc); end
    drive(1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    n_cmp++; if (a_out !== 4'b1110) begin n_bad++; $display("FAIL rt_dep: got %b want %b", a_out, 4'b1110); end
    tick();
    idle();
  endtask

  task automatic test_zero_reg;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);   // lw $0
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
    n_cmp++; if (a_stall_pc !== 1'b0) begin n_bad++; $display("FAIL zero_reg_a: got %b want 0", a_stall_pc); end
    n_cmp++; if (b_stall_pc !== 1'b0) begin n_bad++; $display("FAIL zero_reg_b: got %b want 0", b_stall_pc); end
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    n_cmp++; if (b_stall_pc !== 1'b0) begin n_bad++; $display("FAIL zero_reg_b_mem: got %b want 0", b_stall_pc); end
    tick();
    idle();
  endtask

  task automatic test_fwd_off;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);   // add $8,$1,$2
    tick();
    drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);   // sub $9,$8,$3
    n_cmp++; if (b_out !== 4'b1110) begin n_bad++; $display("FAIL nofwd_stall1: got %b want %b", b_out, 4'b1110); end
    n_cmp++; if (a_stall_pc !== 1'b0) begin n_bad++; $display("FAIL fwd_alu_nostall: got %b want 0", a_stall_pc); end
    tick();
    n_cmp++; if (b_out !== 4'b1110) begin n_bad++; $display("FAIL nofwd_stall2: got %b want %b", b_out, 4'b1110); end
    tick();
    n_cmp++; if (b_out !== 4'b0000) begin n_bad++; $display("FAIL nofwd_wb_free: got %b want %b", b_out, 4'b0000); end
    tick();
    n_cmp++; if (b_cycles !== 16'd2) begin n_bad++; $display("FAIL nofwd_count: got %0d want 2", b_cycles); end
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    n_cmp++; if (b_stall_pc !== 1'b1) begin n_bad++; $display("FAIL nofwd_sub_issued: got %b want 1", b_stall_pc); end
    tick();
    idle();
  endtask

  task automatic test_branch;
    do_reset();
    drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);   // beq taken
    n_cmp++; if (a_out !== 4'b0001) begin n_bad++; $display("FAIL br_flush1_a: got %b want %b", a_out, 4'b0001); end
    n_cmp++; if (b_out !== 4'b0001) begin n_bad++; $display("FAIL br_flush1_b: got %b want %b", b_out, 4'b0001); end
    tick();
    drive(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0); // ignored lw $12 in FLUSH
    n_cmp++; if (a_out !== 4'b0001) begin n_bad++; $display("FAIL br_flush2_a: got %b want %b", a_out, 4'b0001); end
    n_cmp++; if (b_out !== 4'b0000) begin n_bad++; $display("FAIL br_done_b: got %b want %b", b_out, 4'b0000); end
    tick();
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL br_done_a_no_issue: got %b want %b", a_out, 4'b0000); end
    tick();
    idle();
  endtask

  task automatic test_branch_hazard;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);   // lw $8
    tick();
    drive(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);   // beq $8,$9 taken
    n_cmp++; if (a_out !== 4'b1110) begin n_bad++; $display("FAIL brhz_stall: got %b want %b", a_out, 4'b1110); end
    tick();
    n_cmp++; if (a_out !== 4'b0001) begin n_bad++; $display("FAIL brhz_flush: got %b want %b", a_out, 4'b0001); end
    tick();
    idle();
    n_cmp++; if (a_out !== 4'b0001) begin n_bad++; $display("FAIL brhz_flush2: got %b want %b", a_out, 4'b0001); end
    tick();
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL brhz_done: got %b want %b", a_out, 4'b0000); end
    n_cmp++; if (a_cycles !== 16'd1) begin n_bad++; $display("FAIL brhz_count: got %0d want 1", a_cycles); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);   // lw $8
    tick();
    drive(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
    n_cmp++; if (a_out !== 4'b1110) begin n_bad++; $display("FAIL rmid_pre: got %b want %b", a_out, 4'b1110); end
    Reset = 1'b1;
    #1;
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL rmid_forced: got %b want %b", a_out, 4'b0000); end
    tick();
    Reset = 1'b0;
    #1;
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL rmid_stall_abort: got %b want %b", a_out, 4'b0000); end
    n_cmp++; if (a_cycles !== 16'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", a_cycles); end
    tick();
    drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);   // taken branch -> FLUSH
    tick();
    Reset = 1'b1;
    idle();
    tick();
    Reset = 1'b0;
    #1;
    n_cmp++; if (a_out !== 4'b0000) begin n_bad++; $display("FAIL rmid_flush_abort: got %b want %b", a_out, 4'b0000); end
  endtask

  task automatic test_saturation;
    do_reset();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);   // add $5,$5,... repeatedly
    repeat (2048) tick();
    n_cmp++; if (c_cycles !== 16'd1984) begin n_bad++; $display("FAIL sat_partial: got %0d want 1984", c_cycles); end
    repeat (68000) tick();
    n_cmp++; if (c_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", c_cycles); end
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_uses_flags();
    test_zero_reg();
    test_fwd_off();
    test_branch();
    test_branch_hazard();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
